// File: rtl/alu_mc.sv
// Multi-cycle integer execution unit: registered base ALU ops plus iterative
// shift-add multiply and restoring divide, one operation in flight.
module alu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [1:0]      dbg_state_o
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

    // Handshake: a request is taken on an edge where in_valid & in_ready & !kill;
    // a result is consumed on an edge where out_valid & out_ready & !kill.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcd_q, mcd_d;
    logic [XLEN-1:0]   mlr_q, mlr_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            accept, in_is_mul, in_is_div, in_is_rem, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b, base_res;
    logic [SW-1:0]   shamt;

    assign in_ready    = rst_n && (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_result  = result_q;
    assign dbg_state_o = state_q;

    assign accept    = in_valid && in_ready && !kill;
    assign in_is_mul = (in_op[4:2] == 3'b011);
    assign in_is_div = (in_op[4:2] == 3'b100);
    assign in_is_rem = in_is_div && in_op[1];
    // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed.
    assign a_neg = in_a[XLEN-1] && (in_op inside {5'd13, 5'd14, 5'd16, 5'd18});
    assign b_neg = in_b[XLEN-1] && (in_op inside {5'd13, 5'd16, 5'd18});
    assign mag_a = a_neg ? -in_a : in_a;
    assign mag_b = b_neg ? -in_b : in_b;
    assign shamt = in_b[SW-1:0];

    always_comb begin
        base_res = '0;
        case (in_op)
            5'd0:  base_res = in_a + in_b;
            5'd1:  base_res = in_a - in_b;
            5'd2:  base_res = ~in_a;
            5'd3:  base_res = in_a & in_b;
            5'd4:  base_res = in_a | in_b;
            5'd5:  base_res = in_a ^ in_b;
            5'd6:  base_res = {{(XLEN-1){1'b0}}, in_a == in_b};
            5'd7:  base_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            5'd8:  base_res = {{(XLEN-1){1'b0}}, in_a < in_b};
            5'd9:  base_res = in_a << shamt;
            5'd10: base_res = in_a >> shamt;
            5'd11: base_res = $unsigned($signed(in_a) >>> shamt);
            default: base_res = '0;
        endcase
    end

    // One iteration of each datapath; the multiply reuses mcd/mlr as
    // multiplicand/multiplier, the divide as dividend-quotient/divisor.
    logic [2*XLEN-1:0] prod_nx, prod_f;
    logic [XLEN:0]     div_sh, div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   rem_nx, quo_nx, quo_f, rem_f, fin_res;

    always_comb begin
        prod_nx   = acc_q + (mlr_q[0] ? mcd_q : '0);
        prod_f    = neg_q ? -prod_nx : prod_nx;
        div_sh    = {acc_q[XLEN-1:0], mcd_q[XLEN-1]};
        div_trial = div_sh - {1'b0, mlr_q};
        div_ge    = !div_trial[XLEN];
        rem_nx    = div_ge ? div_trial[XLEN-1:0] : div_sh[XLEN-1:0];
        quo_nx    = {mcd_q[XLEN-2:0], div_ge};
        quo_f     = neg_q ? -quo_nx : quo_nx;
        rem_f     = neg_q ? -rem_nx : rem_nx;
        if (op_q[4:2] == 3'b011)
            fin_res = (op_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
        else
            fin_res = op_q[1] ? rem_f : quo_f;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        mcd_d    = mcd_q;
        mlr_d    = mlr_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = in_op;
                    neg_d = in_is_rem ? a_neg : (a_neg ^ b_neg);
                    acc_d = '0;
                    mcd_d = {{XLEN{1'b0}}, mag_a};
                    mlr_d = mag_b;
                    if (in_is_mul || (in_is_div && in_b != '0)) begin
                        state_d = BUSY;
                        cnt_d   = CW'(XLEN);
                    end else begin
                        state_d = DONE;
                        if (in_is_div)
                            result_d = in_is_rem ? in_a : '1;
                        else
                            result_d = base_res;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q[4:2] == 3'b011) begin
                    acc_d = prod_nx;
                    mcd_d = mcd_q << 1;
                    mlr_d = mlr_q >> 1;
                end else begin
                    acc_d = {{XLEN{1'b0}}, rem_nx};
                    mcd_d = {{XLEN{1'b0}}, quo_nx};
                end
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    result_d = fin_res;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcd_q    <= '0;
            mlr_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcd_q    <= mcd_d;
            mlr_q    <= mlr_d;
            result_q <= result_d;
        end
    end
endmodule
